mux_nto1_scan: RTL and testbench
================================

Name: mux_nto1_scan

Overview:
Parametrised, registered N-channel, W-bit multiplexer. Successor to the team's fixed 4:1 single-bit combinational mux.
Adds an auto-scan mode that sequences channels with a programmable dwell, and a valid/ready output handshake.
Sits between parallel sensor/data channels and a single downstream consumer (serialiser, UART framer, display driver).

Parameters:
NUM_CH, 4, number of input channels (>=2).
DATA_W, 8, width of each channel in bits.
DWELL_W, 8, width of the dwell-count input.
SEL_W, $clog2(NUM_CH), select/channel-index width (derived, not overridden).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous, active-high reset.
mode  in  1  0 = manual select, 1 = auto-scan.
sel  in  SEL_W  manual channel select.
dwell  in  DWELL_W  scan: extra accepted samples per channel (0 = one sample per channel).
ch_in  in  NUM_CH*DATA_W  packed channels; channel k = ch_in[k*DATA_W +: DATA_W].
out_data  out  DATA_W  registered selected data.
out_ch  out  SEL_W  index of the channel that produced out_data.
out_valid  out  1  out_data/out_ch valid.
out_ready  in  1  consumer accepts when out_valid && out_ready.

Behaviour:
- Reset (async assert, sync release): out_data=0, out_ch=0, out_valid=0, state=MANUAL, cur_ch=0, dwell_cnt=0.
- Capture slot: load = !out_valid || out_ready. Output regs update only when load=1.
- Latency: one clk from ch_in/sel to out_data.
- Hold rule: when out_valid=1 && out_ready=0, out_data and out_ch are held stable.
- Two-state FSM, states MANUAL and SCAN. Next state = mode, evaluated every cycle.
- Entering SCAN from MANUAL clears cur_ch=0 and dwell_cnt=0. First scan capture is therefore channel 0.
- MANUAL, load=1, sel<NUM_CH: out_data=ch_in[sel], out_ch=sel, out_valid=1.
- MANUAL, load=1, sel>=NUM_CH (non-power-of-2 NUM_CH): out_valid=0, out_data and out_ch hold.
- SCAN, load=1: out_data=ch_in[cur_ch], out_ch=cur_ch, out_valid=1.
  - If dwell_cnt==dwell: dwell_cnt=0 and cur_ch advances, wrapping NUM_CH-1 -> 0.
  - Otherwise dwell_cnt increments.
- Counters advance only on capture. A backpressure stall freezes the scan position.
- dwell changed mid-scan: takes effect at the next comparison.
- If dwell_cnt > new dwell: treat as reached, i.e. advance and clear.
- Leaving SCAN: cur_ch and dwell_cnt hold. The next SCAN entry clears them.
- Reset mid-transfer: out_valid drops immediately. The pending word is discarded.

Optional Feature:
Macro: MUX_CHANNEL_MASK_EN.
- Defined: adds port ch_mask (in, NUM_CH, 1 = channel enabled).
  - SCAN advance skips to the next enabled index (wrap-aware); the search is combinational, single cycle.
  - Entering SCAN starts at the lowest enabled channel.
  - ch_mask all-zero: no capture, out_valid=0 after any pending word is accepted.
  - MANUAL with a masked sel: behaves as out-of-range.
- Undefined: no ch_mask port; all channels are enabled.

Decomposition:
- Shared package mux_pkg holds:
  - typedef mux_mode_e {MODE_MANUAL=0, MODE_SCAN=1}.
  - FSM state enum.
  - function clog2_min1 for the SEL_W derivation.
- One sub-module, mux_scan_ctrl: FSM, cur_ch, dwell_cnt, mask skip logic. Outputs the active index and a capture-enable.
- Top level holds the datapath select and the output register slice.

Test Plan:
1. NUM_CH=4, DATA_W=8, ch_in={0x44,0x33,0x22,0x11}, MANUAL, out_ready=1, sel 0->3 one per cycle -> out_data 0x11,0x22,0x33,0x44 each one clk later, out_ch tracking.
2. SCAN, dwell=0, out_ready=1 -> out_ch sequence 0,1,2,3,0,1, out_valid continuous.
3. SCAN, dwell=2 -> each channel appears 3 consecutive accepted beats, then wraps 3->0.
4. SCAN, out_ready=0 for 5 cycles mid-sequence at out_ch=2 -> out_data/out_ch held. On release the next beat continues the dwell count, no channel skipped.
5. Assert rst asynchronously mid-scan (between clk edges) -> out_valid=0, out_data=0 before the next edge. After release with mode=1, the first capture is ch 0.
6. MUX_CHANNEL_MASK_EN, ch_mask=4'b1010, dwell=0 -> out_ch 1,3,1,3. ch_mask=0 -> out_valid falls after the pending beat is accepted.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared types and helpers for the N:1 registered scanning multiplexer.
package mux_pkg;

  typedef enum logic {
    MODE_MANUAL = 1'b0,
    MODE_SCAN   = 1'b1
  } mux_mode_e;

  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_SCAN   = 1'b1
  } mux_state_e;

  // Width of a channel index; never narrower than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_scan_ctrl.sv
// Channel sequencing for mux_nto1_scan: manual/scan FSM, dwell counting and channel skip.
// Optional MUX_CHANNEL_MASK_EN adds ch_mask; otherwise every channel is enabled.
module mux_scan_ctrl
  import mux_pkg::*;
#(
  parameter int  NUM_CH  = 4,
  parameter int  DWELL_W = 8,
  localparam int SEL_W   = clog2_min1(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               mode,
  input  logic [SEL_W-1:0]   sel,
  input  logic [DWELL_W-1:0] dwell,
`ifdef MUX_CHANNEL_MASK_EN
  input  logic [NUM_CH-1:0]  ch_mask,
`endif
  input  logic               load,
  output logic [SEL_W-1:0]   act_ch,
  output logic               cap_en
);

  mux_state_e         state_q, state_d;
  logic [SEL_W-1:0]   cur_ch_q, cur_ch_d;
  logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
  logic [NUM_CH-1:0]  mask_s;
  logic [SEL_W-1:0]   scan_idx_s, adv_idx_s, first_s;
  logic               any_en_s, sel_ok_s;

`ifdef MUX_CHANNEL_MASK_EN
  assign mask_s = ch_mask;
`else
  assign mask_s = {NUM_CH{1'b1}};
`endif

  // First enabled channel at (incl=1) or after idx, wrapping; idx itself if none enabled.
  function automatic logic [SEL_W-1:0] find_next(input logic [SEL_W-1:0] idx,
                                                 input logic [NUM_CH-1:0] en,
                                                 input logic incl);
    logic [SEL_W-1:0] above, lowest;
    logic             above_ok, any_ok;
    above = idx; lowest = idx; above_ok = 1'b0; any_ok = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (en[k] && ((SEL_W'(k) > idx) || (incl && (SEL_W'(k) == idx)))) begin
        above    = SEL_W'(k);
        above_ok = 1'b1;
      end else begin
        above_ok = above_ok;
      end
      if (en[k]) begin
        lowest = SEL_W'(k);
        any_ok = 1'b1;
      end else begin
        any_ok = any_ok;
      end
    end
    return above_ok ? above : (any_ok ? lowest : idx);
  endfunction

  assign any_en_s   = |mask_s;
  assign scan_idx_s = find_next(cur_ch_q, mask_s, 1'b1);
  assign adv_idx_s  = find_next(scan_idx_s, mask_s, 1'b0);
  assign first_s    = find_next({SEL_W{1'b0}}, mask_s, 1'b1);

  // Manual select is usable only when in range and enabled.
  always_comb begin
    sel_ok_s = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if ((sel == SEL_W'(k)) && mask_s[k]) begin
        sel_ok_s = 1'b1;
      end else begin
        sel_ok_s = sel_ok_s;
      end
    end
  end

  // Next-state and scan position; scan counters move only on an actual capture.
  always_comb begin
    state_d     = (mode == logic'(MODE_SCAN)) ? ST_SCAN : ST_MANUAL;
    cur_ch_d    = cur_ch_q;
    dwell_cnt_d = dwell_cnt_q;
    act_ch      = sel;
    cap_en      = 1'b0;
    case (state_q)
      ST_MANUAL: begin
        act_ch = sel;
        cap_en = sel_ok_s;
        if (state_d == ST_SCAN) begin
          cur_ch_d    = first_s;
          dwell_cnt_d = {DWELL_W{1'b0}};
        end else begin
          cur_ch_d    = cur_ch_q;
        end
      end
      ST_SCAN: begin
        act_ch = scan_idx_s;
        cap_en = any_en_s;
        if (load && any_en_s) begin
          // ">=" so a dwell lowered below the running count advances at once.
          if (dwell_cnt_q >= dwell) begin
            cur_ch_d    = adv_idx_s;
            dwell_cnt_d = {DWELL_W{1'b0}};
          end else begin
            cur_ch_d    = scan_idx_s;
            dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
          end
        end else begin
          cur_ch_d = cur_ch_q;
        end
      end
      default: begin
        state_d = ST_MANUAL;
      end
    endcase
  end

  // State, channel and dwell registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_MANUAL;
      cur_ch_q    <= {SEL_W{1'b0}};
      dwell_cnt_q <= {DWELL_W{1'b0}};
    end else begin
      state_q     <= state_d;
      cur_ch_q    <= cur_ch_d;
      dwell_cnt_q <= dwell_cnt_d;
    end
  end

endmodule

// File: rtl/mux_nto1_scan.sv
// Registered N-channel, W-bit multiplexer with auto-scan and valid/ready output.
// Optional MUX_CHANNEL_MASK_EN adds a per-channel enable mask (ch_mask).
module mux_nto1_scan
  import mux_pkg::*;
#(
  parameter int  NUM_CH  = 4,
  parameter int  DATA_W  = 8,
  parameter int  DWELL_W = 8,
  localparam int SEL_W   = clog2_min1(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mode,
  input  logic [SEL_W-1:0]         sel,
  input  logic [DWELL_W-1:0]       dwell,
  input  logic [NUM_CH*DATA_W-1:0] ch_in,
`ifdef MUX_CHANNEL_MASK_EN
  input  logic [NUM_CH-1:0]        ch_mask,
`endif
  output logic [DATA_W-1:0]        out_data,
  output logic [SEL_W-1:0]         out_ch,
  output logic                     out_valid,
  input  logic                     out_ready
);

  logic [DATA_W-1:0] out_data_q, out_data_d, sel_data_s;
  logic [SEL_W-1:0]  out_ch_q, out_ch_d, act_ch_s;
  logic              out_valid_q, out_valid_d;
  logic              load_s, cap_en_s;

  assign load_s = !out_valid_q || out_ready;

  mux_scan_ctrl #(
    .NUM_CH  (NUM_CH),
    .DWELL_W (DWELL_W)
  ) u_ctrl (
    .clk     (clk),
    .rst     (rst),
    .mode    (mode),
    .sel     (sel),
    .dwell   (dwell),
`ifdef MUX_CHANNEL_MASK_EN
    .ch_mask (ch_mask),
`endif
    .load    (load_s),
    .act_ch  (act_ch_s),
    .cap_en  (cap_en_s)
  );

  // Bounded channel select; an out-of-range index yields zero rather than X.
  always_comb begin
    sel_data_s = {DATA_W{1'b0}};
    for (int k = 0; k < NUM_CH; k++) begin
      if (act_ch_s == SEL_W'(k)) begin
        sel_data_s = ch_in[k*DATA_W +: DATA_W];
      end else begin
        sel_data_s = sel_data_s;
      end
    end
  end

  // Output slice: capture on a free slot, otherwise hold the pending word.
  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    if (load_s) begin
      if (cap_en_s) begin
        out_data_d  = sel_data_s;
        out_ch_d    = act_ch_s;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_q  <= {DATA_W{1'b0}};
      out_ch_q    <= {SEL_W{1'b0}};
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Directed self-checking bench for mux_nto1_scan (NUM_CH=4, DATA_W=8, DWELL_W=8).
module tb_mux_nto1_scan;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  dwell;
  logic [31:0] ch_in;
  logic [7:0]  out_data;
  logic [1:0]  out_ch;
  logic        out_valid;
  logic        out_ready;
`ifdef MUX_CHANNEL_MASK_EN
  logic [3:0]  ch_mask;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] chan_val [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

  mux_nto1_scan #(.NUM_CH(4), .DATA_W(8), .DWELL_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .sel       (sel),
    .dwell     (dwell),
    .ch_in     (ch_in),
`ifdef MUX_CHANNEL_MASK_EN
    .ch_mask   (ch_mask),
`endif
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input string tag, input int ch);
    tick();
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_ch"}, 32'(out_ch), 32'(ch));
    chk({tag, "_data"}, 32'(out_data), 32'(chan_val[ch]));
  endtask

  int seq_scan0 [6]  = '{0, 1, 2, 3, 0, 1};
  int seq_dw2   [13] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int seq_pre   [6]  = '{0, 0, 1, 1, 1, 2};
  int seq_post  [3]  = '{2, 2, 3};
  int seq_shrink[3]  = '{3, 0, 1};

  initial begin
    rst = 1'b1; mode = 1'b0; sel = 2'd0; dwell = 8'd0;
    ch_in = 32'h4433_2211; out_ready = 1'b1;
`ifdef MUX_CHANNEL_MASK_EN
    ch_mask = 4'hF;
`endif
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    tick();
    tick();
    rst = 1'b0;

    // Manual select 0..3
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      beat("manual", i);
    end

    // Backpressure in manual holds the word
    out_ready = 1'b0; sel = 2'd1;
    beat("manual_hold", 3);
    out_ready = 1'b1;

    // Scan with dwell 0; the mode edge itself is still a manual capture
    sel = 2'd2; mode = 1'b1;
    beat("scan_entry", 2);
    for (int i = 0; i < 6; i++) beat("scan_dw0", seq_scan0[i]);

    // Leave and re-enter scan with dwell 2
    mode = 1'b0; dwell = 8'd2; sel = 2'd0;
    beat("scan_exit", 2);
    mode = 1'b1;
    beat("reentry_manual", 0);
    for (int i = 0; i < 13; i++) beat("scan_dw2", seq_dw2[i]);

    // Stall at the first beat of channel 2 and resume mid-dwell
    for (int i = 0; i < 6; i++) beat("pre_stall", seq_pre[i]);
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) beat("stall_hold", 2);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) beat("post_stall", seq_post[i]);

    // Dwell lowered below the running count advances immediately
    dwell = 8'd0;
    for (int i = 0; i < 3; i++) beat("dwell_shrink", seq_shrink[i]);

    // Asynchronous reset between edges
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_data", 32'(out_data), 32'd0);
    chk("async_rst_ch", 32'(out_ch), 32'd0);
    #2;
    rst = 1'b0;
    sel = 2'd0;
    beat("post_rst0", 0);
    beat("post_rst1", 0);
    beat("post_rst2", 1);

`ifdef MUX_CHANNEL_MASK_EN
    mode = 1'b0; sel = 2'd1;
    tick();
    ch_mask = 4'b1010; mode = 1'b1;
    beat("mask_entry", 1);
    beat("mask_s0", 1);
    beat("mask_s1", 3);
    beat("mask_s2", 1);
    beat("mask_s3", 3);
    ch_mask = 4'b0000; out_ready = 1'b0;
    beat("mask_zero_hold", 3);
    out_ready = 1'b1;
    tick();
    chk("mask_zero_valid", 32'(out_valid), 32'd0);
    chk("mask_zero_ch", 32'(out_ch), 32'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
